// File: rtl/mem_block_copier.sv
// mem_block_copier: bus initiator that copies a block of 32-bit words from a
// source base to a destination base in the shared word-addressed memory.
// Each word takes a READ cycle and then a WRITE cycle. Byte order within a
// word can optionally be reversed on the way through.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for start; memory write disabled
//   S_READ  | address = src + idx; read lanes captured into hold regs
//   S_WRITE | address = dst + idx; hold lanes written (swapped if asked)
//   S_DONE  | one-cycle done pulse, then back to S_IDLE
module mem_block_copier #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 128,
    parameter int LEN_W  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [ADDR_W-1:0]     i_src_base,
    input  logic [ADDR_W-1:0]     i_dst_base,
    input  logic [LEN_W-1:0]      i_len,
    input  logic                  i_swap,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [LEN_W-1:0]      o_words_done,
    output logic [ADDR_W-1:0]     o_mem_address,
    output logic [0:3][7:0]       o_mem_wr_data,
    output logic                  o_mem_wr,
    input  logic [0:3][7:0]       i_mem_rd_data
);

    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [ADDR_W-1:0]     r_src;
    logic [ADDR_W-1:0]     r_dst;
    logic [LEN_W-1:0]      r_len;
    logic [LEN_W-1:0]      r_idx;
    logic [LEN_W-1:0]      r_words_done;
    logic                  r_swap;
    logic [0:3][7:0]       r_hold;
    logic [ADDR_W-1:0]     r_addr;
    logic                  r_wr;
    logic                  r_busy;
    logic                  r_done;

    logic [LEN_W-1:0]      w_len_eff;
    logic [LEN_W-1:0]      w_idx_next;

    // Requested length clamped to the memory depth; next word index.
    always_comb begin
        w_len_eff  = (i_len > DEPTH_L) ? DEPTH_L : i_len;
        w_idx_next = r_idx + LEN_W'(1);
    end

    // Copy sequencer. Address and write enable are registered one edge ahead
    // so they are valid for the whole READ/WRITE cycle they belong to; the
    // memory reads combinationally, so a READ always sees earlier writes of
    // the same transfer (forward overlap copies are well defined).
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state      <= S_IDLE;
            r_src        <= '0;
            r_dst        <= '0;
            r_len        <= '0;
            r_idx        <= '0;
            r_words_done <= '0;
            r_swap       <= 1'b0;
            r_hold       <= '0;
            r_addr       <= '0;
            r_wr         <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_wr   <= 1'b0;
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_src        <= i_src_base;
                        r_dst        <= i_dst_base;
                        r_swap       <= i_swap;
                        r_len        <= w_len_eff;
                        r_idx        <= '0;
                        r_words_done <= '0;
                        if (w_len_eff != '0) begin
                            r_state <= S_READ;
                            r_busy  <= 1'b1;
                            r_addr  <= i_src_base;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    r_hold  <= i_mem_rd_data;
                    r_addr  <= r_dst + ADDR_W'(r_idx);
                    r_wr    <= 1'b1;
                    r_state <= S_WRITE;
                end
                S_WRITE: begin
                    r_idx        <= w_idx_next;
                    r_words_done <= r_words_done + LEN_W'(1);
                    r_wr         <= 1'b0;
                    if (w_idx_next == r_len) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_READ;
                        r_addr  <= r_src + ADDR_W'(w_idx_next);
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Write lanes come straight from the hold registers, lane-reversed when
    // the transfer asked for a byte swap.
    always_comb begin
        o_mem_wr_data = r_hold;
        if (r_swap) begin
            for (int i = 0; i < 4; i++) begin
                o_mem_wr_data[i] = r_hold[3-i];
            end
        end
    end

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_words_done  = r_words_done;
    assign o_mem_address = r_addr;
    assign o_mem_wr      = r_wr;

endmodule

// File: doc/mem_block_copier.md
Name: mem_block_copier

Overview:
- Bus initiator for the word-addressed shared memory: copies a block of 32-bit words from a source base address to a destination base address.
- Optionally reverses byte order per word.
- Drives the memory's address, four write-byte lanes and write enable; consumes its four read-byte lanes.
- The memory reads combinationally and writes on the clock edge.
- Sits between the control FSM and the memory; used to stage input data for processing and write results back.

Parameters:
- ADDR_W, 32, memory address width.
- DEPTH, 128, memory depth in words; upper bound on transfer length.
- LEN_W, 8, width of the len input; must hold DEPTH.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request a transfer; sampled only in IDLE.
- src_base  input  ADDR_W  first source word address.
- dst_base  input  ADDR_W  first destination word address.
- len  input  LEN_W  number of words; 0 is legal.
- swap  input  1  1 = reverse bytes within each word.
- busy  output  1  high from the cycle after start is accepted until DONE.
- done  output  1  one-cycle pulse at end of transfer.
- words_done  output  LEN_W  count of words written so far.
- mem_address  output  ADDR_W  memory word address.
- mem_wr_data  output  8 x [0:3]  write byte lanes; lane 0 = word bits 31:24, lane 3 = bits 7:0.
- mem_wr  output  1  memory write enable.
- mem_rd_data  input  8 x [0:3]  read byte lanes, same lane mapping.

Behaviour:
- Reset (rst=0, asynchronous):
  - State = IDLE.
  - busy, done, mem_wr = 0; words_done = 0; mem_address = 0; mem_wr_data lanes = 0; hold registers = 0.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - mem_wr = 0.
  - On a cycle with start=1: latch src_base, dst_base, swap, and len_eff = min(len, DEPTH); clear the index and words_done.
  - Next state is READ if len_eff > 0, otherwise DONE.
  - start is ignored in every other state. No queuing.
- READ:
  - mem_address = src + idx; mem_wr = 0.
  - At the clock edge, capture mem_rd_data into four hold byte registers.
  - Next state: WRITE.
- WRITE:
  - mem_address = dst + idx; mem_wr = 1.
  - mem_wr_data = hold lanes 0..3, or lanes 3..0 when swap=1.
  - At the edge: idx += 1 and words_done += 1.
  - Next state is DONE if idx+1 == len_eff, else READ.
- DONE:
  - done = 1 for exactly this cycle; busy = 0; mem_wr = 0.
  - Next state: IDLE.
- busy is 1 in READ and WRITE, 0 in IDLE and DONE.
- Timing, with start accepted at edge E:
  - Word i is read in cycle E+1+2i and written in cycle E+2+2i.
  - done is high in cycle E+1+2*len_eff.
  - len=0 gives done at E+1 with no memory access.
- Address arithmetic is ADDR_W-bit modulo 2^ADDR_W. No range checking; callers keep addresses below DEPTH.
- Overlapping regions: strictly forward, word-by-word copy. Each read sees all prior writes of the same transfer. This is defined behaviour, not an error.
- mem_address in IDLE and DONE holds its last driven value; mem_wr is 0 there, so the value is don't-care for the memory.
- Reset asserted mid-transfer aborts immediately:
  - Words already written stay written.
  - No done pulse.
  - Outputs go to their reset values asynchronously.

Test Plan:
- Memory preloaded mem[0..3] = 0x11223344, 0x55667788, 0x99AABBCC, 0xDDEEFF00; start with src=0, dst=16, len=4, swap=0 -> mem[16..19] equal the source; done high exactly 9 cycles after the start edge; words_done = 4; mem_wr high in 4 cycles.
- Same setup with swap=1, dst=32 -> mem[32] = 0x44332211, mem[35] = 0x00FFEEDD.
- len=0 -> done one cycle after start; mem_wr never asserted; busy stays 0.
- Overlap: src=0, dst=1, len=3, mem[0] = 0xA5A5A5A5 -> mem[1..3] all 0xA5A5A5A5.
- start pulsed again while busy with different bases -> ignored; only the first transfer's writes occur. len=200 -> clamped to 128, done after 257 cycles.
- rst driven low during the WRITE of word 2 of a 4-word copy -> busy, mem_wr and words_done drop to 0 without a clock edge; mem[dst+2] and mem[dst+3] unchanged; no done pulse; a fresh start after release works normally.
